// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and the
// per-instruction address increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request outstanding
    ST_REQ  = 2'd1,  // request outstanding, data will be kept
    ST_DROP = 2'd2   // request outstanding, data will be thrown away
  } fetch_state_e;

  localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead prefetch buffer: the head entry is presented combinationally,
// push and pop may happen together, and flush empties it synchronously.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             push_en;
  logic             pop_en;

  assign valid_o = (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  // A pop frees a slot in the same cycle, so a push into a full buffer is
  // accepted when it coincides with a pop; flush overrides both.
  assign pop_en  = pop_i && valid_o && !flush_i;
  assign push_en = push_i && !flush_i && (!full || pop_en);
  // The head is masked while empty so stale storage never leaks out.
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  // Next pointer/occupancy values from flush, push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_en && !pop_en)      count_d = count_q + CW'(1);
      else if (!push_en && pop_en) count_d = count_q - CW'(1);
    end
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only ever read behind a valid count.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one read at a time to instruction memory,
// buffers returned words with their PC, and restarts on redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [XLEN-1:0]          mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     ir_ready,
  output logic                     ir_valid,
  output logic [31:0]              ir_out,
  output logic [XLEN-1:0]          ir_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   redirect_pc_al;
  logic              pop;
  logic              push;
  logic [CW-1:0]     occ_after_pop;
  logic              room_now;
  logic              room_after_push;
  logic [XLEN+31:0]  fifo_head;

  assign redirect_pc_al  = redirect_pc & ~XLEN'(3);
  assign pop             = ir_valid && ir_ready;
  assign occ_after_pop   = count - CW'(pop);
  assign room_now        = ({1'b0, occ_after_pop} < (CW+1)'(DEPTH));
  assign room_after_push = (({1'b0, occ_after_pop} + (CW+1)'(1)) < (CW+1)'(DEPTH));

  // Outputs depend only on registered state, so mem_ack never reaches mem_req.
  assign mem_req  = (state_q != ST_IDLE);
  assign mem_addr = fetch_pc_q;
  assign ir_pc    = fifo_head[XLEN+31:32];
  assign ir_out   = fifo_head[31:0];

  // Next-state, next fetch address and push decision.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A late ack here belongs to an abandoned request and is ignored.
        if (redirect) begin
          fetch_pc_d = redirect_pc_al;
          state_d    = ST_REQ;
        end else if (room_now) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc_al;
          state_d    = mem_ack ? ST_REQ : ST_DROP;
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + XLEN'(INSN_BYTES);
          state_d    = room_after_push ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (redirect) fetch_pc_d = redirect_pc_al;
        if (mem_ack)  state_d    = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and fetch address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (push),
    .data_i  ({fetch_pc_q, mem_rdata}),
    .pop_i   (ir_ready),
    .data_o  (fifo_head),
    .valid_o (ir_valid),
    .count_o (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (XLEN=64, DEPTH=4, RESET_PC=0).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        ir_ready;
  logic        ir_valid;
  logic [31:0] ir_out;
  logic [63:0] ir_pc;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir_ready    (ir_ready),
    .ir_valid    (ir_valid),
    .ir_out      (ir_out),
    .ir_pc       (ir_pc),
    .count       (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Memory word returned for an address in this bench.
  function automatic logic [31:0] word(input logic [63:0] a);
    return 32'hA000_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; redirect = 1'b0;
    redirect_pc = '0; ir_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b want 0", mem_req); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", ir_valid); end
    checks++; if (ir_out !== 32'h0) begin errors++; $display("FAIL rst_ir_out: got %h want 0", ir_out); end
    checks++; if (ir_pc !== 64'h0) begin errors++; $display("FAIL rst_ir_pc: got %h want 0", ir_pc); end
    checks++; if (mem_addr !== 64'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    rst = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %0b want 1", mem_req); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_addr !== 64'(4*i)) begin errors++; $display("FAIL fill_addr%0d: got %h want %h", i, mem_addr, 64'(4*i)); end
      tick();
      mem_ack = 1'b1; mem_rdata = word(64'(4*i));
      tick();
      mem_ack = 1'b0;
      checks++; if (count !== 3'(i+1)) begin errors++; $display("FAIL fill_count%0d: got %0d want %0d", i, count, i+1); end
      if (i == 0) begin
        checks++; if (ir_out !== word(64'h0)) begin errors++; $display("FAIL fill_latency: got %h want %h", ir_out, word(64'h0)); end
      end
    end
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fill_req_drop: got %0b want 0", mem_req); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_full: got %0d want 4", count); end
    checks++; if (ir_pc !== 64'h0) begin errors++; $display("FAIL fill_ir_pc: got %h want 0", ir_pc); end
  endtask

  task automatic test_full_pop();
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL pop_count: got %0d want 3", count); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h10) begin errors++; $display("FAIL pop_req: got req=%0b addr=%h want req=1 addr=10", mem_req, mem_addr); end
    checks++; if (ir_pc !== 64'h4 || ir_out !== word(64'h4)) begin errors++; $display("FAIL pop_head: got pc=%h ir=%h want pc=4 ir=%h", ir_pc, ir_out, word(64'h4)); end
    mem_ack = 1'b1; mem_rdata = word(64'h10);
    tick();
    mem_ack = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL pop_refill: got %0d want 4", count); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL pop_idle: got %0b want 0", mem_req); end
  endtask

  task automatic test_redirect_idle();
    redirect = 1'b1; redirect_pc = 64'h400;
    tick();
    redirect = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL ridle_flush: got %0d want 0", count); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h400) begin errors++; $display("FAIL ridle_req: got req=%0b addr=%h want req=1 addr=400", mem_req, mem_addr); end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    rst = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = word(64'h0);
    tick();
    mem_rdata = word(64'h4);
    tick();
    mem_ack = 1'b0;
    checks++; if (mem_addr !== 64'h8 || count !== 3'd2) begin errors++; $display("FAIL rdrop_pre: got addr=%h count=%0d want addr=8 count=2", mem_addr, count); end
    redirect = 1'b1; redirect_pc = 64'h1002; ir_ready = 1'b1;
    tick();
    redirect = 1'b0;
    checks++; if (count !== 3'd0 || ir_valid !== 1'b0) begin errors++; $display("FAIL rdrop_flush: got count=%0d valid=%0b want 0 0", count, ir_valid); end
    tick();
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rdrop_ready_empty: got %0d want 0", count); end
    ir_ready = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    checks++; if (count !== 3'd0 || ir_valid !== 1'b0) begin errors++; $display("FAIL rdrop_discard: got count=%0d valid=%0b want 0 0", count, ir_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin errors++; $display("FAIL rdrop_newaddr: got req=%0b addr=%h want req=1 addr=1000", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = word(64'h1000);
    tick();
    mem_ack = 1'b0;
    checks++; if (count !== 3'd1 || ir_pc !== 64'h1000 || ir_out !== word(64'h1000)) begin errors++; $display("FAIL rdrop_data: got count=%0d pc=%h ir=%h want 1 1000 %h", count, ir_pc, ir_out, word(64'h1000)); end
    checks++; if (mem_addr !== 64'h1004) begin errors++; $display("FAIL rdrop_next: got %h want 1004", mem_addr); end
  endtask

  task automatic test_redirect_ack();
    redirect = 1'b1; redirect_pc = 64'h2003; mem_ack = 1'b1; mem_rdata = 32'hBAD0_0001; ir_ready = 1'b1;
    tick();
    redirect = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0;
    checks++; if (count !== 3'd0 || ir_valid !== 1'b0) begin errors++; $display("FAIL rack_nopush: got count=%0d valid=%0b want 0 0", count, ir_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h2000) begin errors++; $display("FAIL rack_addr: got req=%0b addr=%h want req=1 addr=2000", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = word(64'h2000);
    tick();
    mem_ack = 1'b0;
    checks++; if (count !== 3'd1 || ir_pc !== 64'h2000) begin errors++; $display("FAIL rack_data: got count=%0d pc=%h want 1 2000", count, ir_pc); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect = 1'b0;
    checks++; if (mem_addr !== 64'hFFFF_FFFF_FFFF_FFFC || count !== 3'd0) begin errors++; $display("FAIL wrap_redir: got addr=%h count=%0d want fffffffffffffffc 0", mem_addr, count); end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_drop: got %0d want 0", count); end
    mem_ack = 1'b1; mem_rdata = 32'hA000_FFFC;
    tick();
    mem_ack = 1'b0;
    checks++; if (ir_pc !== 64'hFFFF_FFFF_FFFF_FFFC || ir_out !== 32'hA000_FFFC) begin errors++; $display("FAIL wrap_head: got pc=%h ir=%h want fffffffffffffffc a000fffc", ir_pc, ir_out); end
    checks++; if (mem_addr !== 64'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", mem_addr); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || count !== 3'd0 || ir_valid !== 1'b0) begin errors++; $display("FAIL rmid_async: got req=%0b count=%0d valid=%0b want 0 0 0", mem_req, count, ir_valid); end
    tick();
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0;
    checks++; if (count !== 3'd0 || ir_valid !== 1'b0) begin errors++; $display("FAIL rmid_late_ack: got count=%0d valid=%0b want 0 0", count, ir_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h0) begin errors++; $display("FAIL rmid_addr: got req=%0b addr=%h want req=1 addr=0", mem_req, mem_addr); end
  endtask

  task automatic test_back_to_back();
    mem_ack = 1'b1; mem_rdata = word(64'h0); ir_ready = 1'b1;
    tick();
    checks++; if (count !== 3'd1 || ir_pc !== 64'h0) begin errors++; $display("FAIL b2b_first: got count=%0d pc=%h want 1 0", count, ir_pc); end
    for (int i = 1; i < 4; i++) begin
      mem_rdata = word(64'(4*i));
      tick();
      checks++; if (count !== 3'd1 || ir_pc !== 64'(4*i) || ir_out !== word(64'(4*i))) begin errors++; $display("FAIL b2b_%0d: got count=%0d pc=%h ir=%h want 1 %h %h", i, count, ir_pc, ir_out, 64'(4*i), word(64'(4*i))); end
      checks++; if (mem_addr !== 64'(4*(i+1))) begin errors++; $display("FAIL b2b_addr%0d: got %h want %h", i, mem_addr, 64'(4*(i+1))); end
    end
    mem_ack = 1'b0; ir_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_redirect_idle();
    test_redirect_drop();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 64, address/PC width in bits.
REQ-002 Parameter DEPTH, default 4, prefetch buffer entries; power of two, 2..16.
REQ-003 Parameter RESET_PC, default 0, fetch address after reset; bits [1:0] zero.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 mem_req  out  1  instruction-memory read request.
REQ-007 mem_addr  out  XLEN  request byte address.
REQ-008 mem_ack  in  1  memory has returned data for the current request.
REQ-009 mem_rdata  in  32  instruction word, valid when mem_ack is high.
REQ-010 redirect  in  1  flush and restart fetch (branch/jump taken).
REQ-011 redirect_pc  in  XLEN  new fetch address.
REQ-012 ir_ready  in  1  consumer takes the head instruction (load-IR).
REQ-013 ir_valid  out  1  head instruction present.
REQ-014 ir_out  out  32  head instruction word.
REQ-015 ir_pc  out  XLEN  address of head instruction.
REQ-016 count  out  $clog2(DEPTH)+1  buffered instruction count.

Function
REQ-017 FSM states: IDLE (no request), REQ (request outstanding), DROP (outstanding request whose data is discarded).
REQ-018 mem_req SHALL be high exactly in REQ and DROP; mem_addr SHALL hold fetch_pc stable until mem_ack.
REQ-019 At most one request SHALL be outstanding.
REQ-020 IDLE->REQ when count (after this cycle's pop) < DEPTH and no redirect.
REQ-021 In REQ with mem_ack: push {fetch_pc, mem_rdata}; fetch_pc += 4, wrapping modulo 2^XLEN; stay REQ if count+1-pop < DEPTH, else IDLE.
REQ-022 mem_ack while in IDLE SHALL be ignored.
REQ-023 Buffer is show-ahead: ir_valid/ir_out/ir_pc reflect the head entry; pop occurs on edge with ir_valid && ir_ready.
REQ-024 ir_ready with ir_valid low SHALL have no effect.
REQ-025 Push and pop in the same cycle SHALL both occur; count unchanged, including when full.
REQ-026 Redirect: empty the buffer, fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; a pop in the same cycle is discarded.
REQ-027 Redirect in REQ without mem_ack -> DROP; with mem_ack -> data discarded, next state REQ.
REQ-028 Redirect in IDLE -> REQ; new address appears on mem_addr the next cycle.
REQ-029 DROP with mem_ack: data discarded, -> REQ at the new fetch_pc; a further redirect in DROP only updates fetch_pc.
REQ-030 Latency: data acked on edge N SHALL be visible on ir_out after edge N (one cycle), when the buffer was empty.

Reset
REQ-031 On rst: state IDLE, fetch_pc = RESET_PC, buffer empty, count 0, ir_valid 0, mem_req 0; ir_out and ir_pc 0.
REQ-032 Reset mid-request SHALL abandon the request; a late mem_ack after reset while in IDLE is ignored.
REQ-033 First request SHALL issue on the first edge after rst deasserts.

Structure
REQ-034 Package fetch_pkg SHALL hold the FSM state enum and the instruction-increment constant (4).
REQ-035 Buffer SHALL be a sub-module fetch_fifo (parametrised width/depth, synchronous flush, push/pop/count).
REQ-036 fetch_unit SHALL hold the FSM and fetch_pc only; no combinational path from mem_ack to mem_req.

Verification
REQ-037 Reset release, ack one cycle after each request, ir_ready low -> addresses 0,4,8,12 fetched, count=4, mem_req drops, ir_pc=0.
REQ-038 Full buffer, ir_ready pulsed one cycle -> count 3, one request to 16 issues, count returns to 4.
REQ-039 Redirect to 0x1002 while request to 8 pending, ack 3 cycles later -> ack data dropped, next mem_addr 0x1000, buffer empty until it acks.
REQ-040 Redirect and mem_ack same cycle -> data not pushed, next request to redirect_pc.
REQ-041 fetch_pc = 2^XLEN-4 acked -> next mem_addr 0.
REQ-042 rst asserted while mem_req high, mem_ack the cycle after release -> nothing pushed, mem_addr = RESET_PC.
